// File: rtl/bram_arbiter_if.sv
// Request/response bundle shared by the CPU/DMA requesters, the arbiter and the BRAM controller port.
// The slave modport is the arbiter's view; the master modport is the requester/controller side.
interface bram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic              dma_req_valid;
  logic              dma_req_ready;
  logic              dma_req_we;
  logic [ADDR_W-1:0] dma_req_addr;
  logic [DATA_W-1:0] dma_req_wdata;
  logic              cpu_resp_valid;
  logic              dma_resp_valid;
  logic              WR;
  logic              In_valid;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Di;
  logic              reader_sel;
  logic              dma_wr_done;
  logic              resp_err;

  modport master (
    output cpu_req_valid, cpu_req_addr,
    output dma_req_valid, dma_req_we, dma_req_addr, dma_req_wdata,
    output cpu_resp_valid, dma_resp_valid,
    input  cpu_req_ready, dma_req_ready,
    input  WR, In_valid, Addr, Di, reader_sel, dma_wr_done, resp_err
  );

  modport slave (
    input  cpu_req_valid, cpu_req_addr,
    input  dma_req_valid, dma_req_we, dma_req_addr, dma_req_wdata,
    input  cpu_resp_valid, dma_resp_valid,
    output cpu_req_ready, dma_req_ready,
    output WR, In_valid, Addr, Di, reader_sel, dma_wr_done, resp_err
  );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter merging CPU reads and DMA reads/writes onto the BRAM controller request port,
// with per-master read credits bounding in-flight reads against the fixed-latency controller pipeline.
module bram_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input logic         clk,
  input logic         rst_n,
  bram_arbiter_if.slave bus
);

  typedef enum logic {
    GRANT_DMA = 1'b0,
    GRANT_CPU = 1'b1
  } grant_e;

  localparam logic [3:0] CREDIT_MAX = 4'(MAX_OUTST);

  grant_e            last_grant;
  grant_e            next_grant;

  logic              cpu_hold_valid;
  logic [ADDR_W-1:0] cpu_hold_addr;
  logic              dma_hold_valid;
  logic              dma_hold_we;
  logic [ADDR_W-1:0] dma_hold_addr;
  logic [DATA_W-1:0] dma_hold_wdata;

  logic [3:0]        cpu_cnt;
  logic [3:0]        dma_cnt;
  logic [3:0]        cpu_cnt_nxt;
  logic [3:0]        dma_cnt_nxt;
  logic              cpu_spurious;
  logic              dma_spurious;

  logic              cpu_elig;
  logic              dma_elig;
  logic              grant_cpu;
  logic              grant_dma;

  logic              nxt_in_valid;
  logic              nxt_wr;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_di;
  logic              nxt_reader_sel;
  logic              nxt_wr_done;

  assign cpu_elig = cpu_hold_valid && (cpu_cnt < CREDIT_MAX);
  assign dma_elig = dma_hold_valid && (dma_hold_we || (dma_cnt < CREDIT_MAX));

  // Ready only looks at registered state, so a requester never sees a combinational loop through valid.
  assign bus.cpu_req_ready = !cpu_hold_valid || grant_cpu;
  assign bus.dma_req_ready = !dma_hold_valid || grant_dma;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_DMA;
    end else begin
      last_grant <= next_grant;
    end
  end

  always_comb begin
    grant_cpu  = cpu_elig && (!dma_elig || (last_grant == GRANT_DMA));
    grant_dma  = dma_elig && !grant_cpu;
    next_grant = last_grant;
    if (grant_cpu) begin
      next_grant = GRANT_CPU;
    end else if (grant_dma) begin
      next_grant = GRANT_DMA;
    end
  end

  always_comb begin
    nxt_in_valid   = 1'b0;
    nxt_wr         = 1'b0;
    nxt_addr       = '0;
    nxt_di         = '0;
    nxt_reader_sel = 1'b0;
    nxt_wr_done    = 1'b0;
    if (grant_cpu) begin
      nxt_in_valid   = 1'b1;
      nxt_addr       = cpu_hold_addr;
      nxt_reader_sel = 1'b1;
    end else if (grant_dma) begin
      nxt_in_valid = 1'b1;
      nxt_wr       = dma_hold_we;
      nxt_addr     = dma_hold_addr;
      nxt_di       = dma_hold_we ? dma_hold_wdata : '0;
      nxt_wr_done  = dma_hold_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.In_valid    <= 1'b0;
      bus.WR          <= 1'b0;
      bus.Addr        <= '0;
      bus.Di          <= '0;
      bus.reader_sel  <= 1'b0;
      bus.dma_wr_done <= 1'b0;
    end else begin
      bus.In_valid    <= nxt_in_valid;
      bus.WR          <= nxt_wr;
      bus.Addr        <= nxt_addr;
      bus.Di          <= nxt_di;
      bus.reader_sel  <= nxt_reader_sel;
      bus.dma_wr_done <= nxt_wr_done;
    end
  end

  // A hold slot refills in the same cycle it drains, giving one acceptance per cycle per master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_hold_valid <= 1'b0;
      cpu_hold_addr  <= '0;
      dma_hold_valid <= 1'b0;
      dma_hold_we    <= 1'b0;
      dma_hold_addr  <= '0;
      dma_hold_wdata <= '0;
    end else begin
      if (bus.cpu_req_valid && bus.cpu_req_ready) begin
        cpu_hold_valid <= 1'b1;
        cpu_hold_addr  <= bus.cpu_req_addr;
      end else if (grant_cpu) begin
        cpu_hold_valid <= 1'b0;
      end
      if (bus.dma_req_valid && bus.dma_req_ready) begin
        dma_hold_valid <= 1'b1;
        dma_hold_we    <= bus.dma_req_we;
        dma_hold_addr  <= bus.dma_req_addr;
        dma_hold_wdata <= bus.dma_req_wdata;
      end else if (grant_dma) begin
        dma_hold_valid <= 1'b0;
      end
    end
  end

  // A response with no read in flight is spurious: it is flagged and never drives a count below zero.
  always_comb begin
    cpu_cnt_nxt  = cpu_cnt;
    dma_cnt_nxt  = dma_cnt;
    cpu_spurious = bus.cpu_resp_valid && (cpu_cnt == 4'd0);
    dma_spurious = bus.dma_resp_valid && (dma_cnt == 4'd0);
    case ({grant_cpu, bus.cpu_resp_valid && !cpu_spurious})
      2'b10:   cpu_cnt_nxt = cpu_cnt + 4'd1;
      2'b01:   cpu_cnt_nxt = cpu_cnt - 4'd1;
      default: cpu_cnt_nxt = cpu_cnt;
    endcase
    case ({grant_dma && !dma_hold_we, bus.dma_resp_valid && !dma_spurious})
      2'b10:   dma_cnt_nxt = dma_cnt + 4'd1;
      2'b01:   dma_cnt_nxt = dma_cnt - 4'd1;
      default: dma_cnt_nxt = dma_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_cnt      <= 4'd0;
      dma_cnt      <= 4'd0;
      bus.resp_err <= 1'b0;
    end else begin
      cpu_cnt      <= cpu_cnt_nxt;
      dma_cnt      <= dma_cnt_nxt;
      bus.resp_err <= bus.resp_err || cpu_spurious || dma_spurious;
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Scenario bench for bram_arbiter: accepted requests are queued per master and popped when issued.
module tb_bram_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] di;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;
  int   wr_done_seen = 0;
  txn_t cpu_q[$];
  txn_t dma_q[$];
  logic sel_hist[$];

  bram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.cpu_req_valid  = 1'b0;
    bus.cpu_req_addr   = '0;
    bus.dma_req_valid  = 1'b0;
    bus.dma_req_we     = 1'b0;
    bus.dma_req_addr   = '0;
    bus.dma_req_wdata  = '0;
    bus.cpu_resp_valid = 1'b0;
    bus.dma_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cpu_q.delete();
    dma_q.delete();
    sel_hist.delete();
    rst_n = 1'b1;
  endtask

  // One clock: record acceptances, then check whatever the DUT issued against the per-master queues.
  task automatic tick();
    txn_t t;
    if (bus.cpu_req_valid && bus.cpu_req_ready)
      cpu_q.push_back({1'b0, bus.cpu_req_addr, 32'h0});
    if (bus.dma_req_valid && bus.dma_req_ready)
      dma_q.push_back({bus.dma_req_we, bus.dma_req_addr, bus.dma_req_we ? bus.dma_req_wdata : 32'h0});
    @(posedge clk);
    #1;
    wr_done_seen += int'(bus.dma_wr_done);
    checks++;
    if (!bus.In_valid) begin
      if ({bus.WR, bus.Addr, bus.Di, bus.reader_sel, bus.dma_wr_done} !== 48'h0)
        $display("[TB] FAIL idle_outputs: got WR=%b Addr=%h Di=%h sel=%b done=%b, expected all 0",
                 bus.WR, bus.Addr, bus.Di, bus.reader_sel, bus.dma_wr_done);
      else passes++;
    end else begin
      sel_hist.push_back(bus.reader_sel);
      if (bus.reader_sel) begin
        if (cpu_q.size() == 0) begin
          $display("[TB] FAIL cpu_issue: got issue Addr=%h, expected no CPU issue", bus.Addr);
        end else begin
          t = cpu_q.pop_front();
          if ({bus.WR, bus.Addr, bus.Di, bus.dma_wr_done} !== {t.wr, t.addr, t.di, 1'b0})
            $display("[TB] FAIL cpu_issue: got WR=%b Addr=%h Di=%h done=%b, expected WR=%b Addr=%h Di=%h done=0",
                     bus.WR, bus.Addr, bus.Di, bus.dma_wr_done, t.wr, t.addr, t.di);
          else passes++;
        end
      end else begin
        if (dma_q.size() == 0) begin
          $display("[TB] FAIL dma_issue: got issue Addr=%h, expected no DMA issue", bus.Addr);
        end else begin
          t = dma_q.pop_front();
          if ({bus.WR, bus.Addr, bus.Di, bus.dma_wr_done} !== {t.wr, t.addr, t.di, t.wr})
            $display("[TB] FAIL dma_issue: got WR=%b Addr=%h Di=%h done=%b, expected WR=%b Addr=%h Di=%h done=%b",
                     bus.WR, bus.Addr, bus.Di, bus.dma_wr_done, t.wr, t.addr, t.di, t.wr);
          else passes++;
        end
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.In_valid, bus.WR, bus.Addr, bus.Di, bus.reader_sel, bus.dma_wr_done, bus.resp_err} !== 50'h0)
      $display("[TB] FAIL reset_outputs: got In_valid=%b WR=%b Addr=%h Di=%h sel=%b, expected all 0",
               bus.In_valid, bus.WR, bus.Addr, bus.Di, bus.reader_sel);
    else passes++;
    do_reset();
    checks++;
    if ({dut.cpu_cnt, dut.dma_cnt} !== 8'h00)
      $display("[TB] FAIL reset_credits: got cpu=%0d dma=%0d, expected 0/0", dut.cpu_cnt, dut.dma_cnt);
    else passes++;
    checks++;
    if ({bus.cpu_req_ready, bus.dma_req_ready} !== 2'b11)
      $display("[TB] FAIL reset_ready: got %b, expected 11", {bus.cpu_req_ready, bus.dma_req_ready});
    else passes++;
  endtask

  task automatic test_single_cpu_read();
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 13'h0040;
    tick();
    bus.cpu_req_valid = 1'b0;
    checks++;
    if (bus.In_valid !== 1'b0)
      $display("[TB] FAIL single_latency: got In_valid=%b at acceptance edge, expected 0", bus.In_valid);
    else passes++;
    tick();
    checks++;
    if ({bus.In_valid, bus.WR, bus.reader_sel, bus.Addr} !== {1'b1, 1'b0, 1'b1, 13'h0040})
      $display("[TB] FAIL single_issue: got In_valid=%b WR=%b sel=%b Addr=%h, expected 1 0 1 0040",
               bus.In_valid, bus.WR, bus.reader_sel, bus.Addr);
    else passes++;
    checks++;
    if (dut.cpu_cnt !== 4'd1)
      $display("[TB] FAIL single_cnt_inc: got %0d, expected 1", dut.cpu_cnt);
    else passes++;
    bus.cpu_resp_valid = 1'b1;
    tick();
    bus.cpu_resp_valid = 1'b0;
    checks++;
    if (dut.cpu_cnt !== 4'd0)
      $display("[TB] FAIL single_cnt_dec: got %0d, expected 0", dut.cpu_cnt);
    else passes++;
  endtask

  task automatic test_alternation();
    logic [7:0] pattern;
    do_reset();
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 13'h0200;
    bus.dma_req_valid = 1'b1;
    bus.dma_req_we    = 1'b0;
    bus.dma_req_addr  = 13'h0300;
    for (int i = 0; i < 12; i++) begin
      logic ca;
      logic da;
      ca = bus.cpu_req_ready;
      da = bus.dma_req_ready;
      tick();
      if (ca) bus.cpu_req_addr = bus.cpu_req_addr + 13'd1;
      if (da) bus.dma_req_addr = bus.dma_req_addr + 13'd1;
    end
    idle_inputs();
    checks++;
    if (sel_hist.size() != 8)
      $display("[TB] FAIL alt_issue_count: got %0d issues, expected 8", sel_hist.size());
    else passes++;
    pattern = '0;
    for (int i = 0; i < 8 && i < sel_hist.size(); i++) pattern[7-i] = sel_hist[i];
    checks++;
    if (pattern !== 8'b1010_1010)
      $display("[TB] FAIL alt_pattern: got %b, expected 10101010", pattern);
    else passes++;
  endtask

  task automatic test_credit_limit();
    int accepted;
    int cpu_issues;
    do_reset();
    accepted = 0;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 13'h0100;
    for (int i = 0; i < 10; i++) begin
      logic ca;
      ca = bus.cpu_req_ready;
      tick();
      if (ca) begin
        accepted++;
        bus.cpu_req_addr = bus.cpu_req_addr + 13'd1;
      end
    end
    cpu_issues = 0;
    foreach (sel_hist[i]) cpu_issues += int'(sel_hist[i]);
    checks++;
    if (cpu_issues != 4 || accepted != 5)
      $display("[TB] FAIL credit_stall: got issued=%0d accepted=%0d, expected 4/5", cpu_issues, accepted);
    else passes++;
    checks++;
    if (bus.cpu_req_ready !== 1'b0)
      $display("[TB] FAIL credit_ready: got %b, expected 0", bus.cpu_req_ready);
    else passes++;
    bus.cpu_resp_valid = 1'b1;
    tick();
    bus.cpu_resp_valid = 1'b0;
    checks++;
    if (bus.In_valid !== 1'b0)
      $display("[TB] FAIL credit_resp_cycle: got In_valid=%b, expected 0", bus.In_valid);
    else passes++;
    tick();
    bus.cpu_req_valid = 1'b0;
    checks++;
    if ({bus.In_valid, bus.reader_sel, bus.Addr} !== {1'b1, 1'b1, 13'h0104})
      $display("[TB] FAIL credit_fifth: got In_valid=%b sel=%b Addr=%h, expected 1 1 0104",
               bus.In_valid, bus.reader_sel, bus.Addr);
    else passes++;
  endtask

  task automatic test_dma_write();
    wr_done_seen = 0;
    bus.dma_req_valid = 1'b1;
    bus.dma_req_we    = 1'b1;
    bus.dma_req_addr  = 13'h1FFF;
    bus.dma_req_wdata = 32'hDEADBEEF;
    tick();
    idle_inputs();
    tick();
    checks++;
    if ({bus.In_valid, bus.WR, bus.reader_sel, bus.dma_wr_done, bus.Addr, bus.Di} !==
        {1'b1, 1'b1, 1'b0, 1'b1, 13'h1FFF, 32'hDEADBEEF})
      $display("[TB] FAIL dma_write: got In_valid=%b WR=%b sel=%b done=%b Addr=%h Di=%h, expected 1 1 0 1 1FFF DEADBEEF",
               bus.In_valid, bus.WR, bus.reader_sel, bus.dma_wr_done, bus.Addr, bus.Di);
    else passes++;
    repeat (2) tick();
    checks++;
    if (wr_done_seen != 1)
      $display("[TB] FAIL dma_wr_done_pulses: got %0d, expected 1", wr_done_seen);
    else passes++;
    checks++;
    if (dut.dma_cnt !== 4'd0)
      $display("[TB] FAIL dma_write_credits: got %0d, expected 0", dut.dma_cnt);
    else passes++;
  endtask

  task automatic test_coincident_and_spurious();
    do_reset();
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 13'h0010;
    tick();
    bus.cpu_req_addr  = 13'h0011;
    tick();
    bus.cpu_req_valid = 1'b0;
    tick();
    checks++;
    if (dut.cpu_cnt !== 4'd2)
      $display("[TB] FAIL coinc_pre_cnt: got %0d, expected 2", dut.cpu_cnt);
    else passes++;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 13'h0012;
    tick();
    bus.cpu_req_valid  = 1'b0;
    bus.cpu_resp_valid = 1'b1;
    tick();
    bus.cpu_resp_valid = 1'b0;
    checks++;
    if ({bus.In_valid, bus.reader_sel, dut.cpu_cnt} !== {1'b1, 1'b1, 4'd2})
      $display("[TB] FAIL coinc_cnt: got In_valid=%b sel=%b cnt=%0d, expected 1 1 2",
               bus.In_valid, bus.reader_sel, dut.cpu_cnt);
    else passes++;
    checks++;
    if (bus.resp_err !== 1'b0)
      $display("[TB] FAIL resp_err_early: got %b, expected 0", bus.resp_err);
    else passes++;
    bus.dma_resp_valid = 1'b1;
    tick();
    bus.dma_resp_valid = 1'b0;
    checks++;
    if ({bus.resp_err, dut.dma_cnt} !== {1'b1, 4'd0})
      $display("[TB] FAIL spurious_resp: got resp_err=%b dma_cnt=%0d, expected 1 0", bus.resp_err, dut.dma_cnt);
    else passes++;
    repeat (3) tick();
    checks++;
    if (bus.resp_err !== 1'b1)
      $display("[TB] FAIL resp_err_sticky: got %b, expected 1", bus.resp_err);
    else passes++;
  endtask

  task automatic test_reset_mid_burst();
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 13'h0500;
    bus.dma_req_valid = 1'b1;
    bus.dma_req_we    = 1'b0;
    bus.dma_req_addr  = 13'h0600;
    repeat (3) tick();
    checks++;
    if (bus.In_valid !== 1'b1)
      $display("[TB] FAIL burst_active: got In_valid=%b, expected 1", bus.In_valid);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.In_valid, bus.WR, bus.Addr, bus.Di, bus.reader_sel, bus.dma_wr_done, bus.resp_err} !== 50'h0)
      $display("[TB] FAIL async_reset: got In_valid=%b sel=%b Addr=%h resp_err=%b, expected all 0",
               bus.In_valid, bus.reader_sel, bus.Addr, bus.resp_err);
    else passes++;
    idle_inputs();
    cpu_q.delete();
    dma_q.delete();
    sel_hist.delete();
    #1;
    rst_n = 1'b1;
    checks++;
    if ({bus.cpu_req_ready, bus.dma_req_ready, dut.cpu_cnt, dut.dma_cnt} !== {2'b11, 8'h00})
      $display("[TB] FAIL post_reset_state: got ready=%b%b cnt=%0d/%0d, expected 11 0/0",
               bus.cpu_req_ready, bus.dma_req_ready, dut.cpu_cnt, dut.dma_cnt);
    else passes++;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 13'h0700;
    bus.dma_req_valid = 1'b1;
    bus.dma_req_addr  = 13'h0800;
    tick();
    idle_inputs();
    tick();
    checks++;
    if ({bus.In_valid, bus.reader_sel} !== 2'b11)
      $display("[TB] FAIL post_reset_tie: got In_valid=%b sel=%b, expected 1 1", bus.In_valid, bus.reader_sel);
    else passes++;
    tick();
    checks++;
    if ({bus.In_valid, bus.reader_sel} !== 2'b10)
      $display("[TB] FAIL post_reset_second: got In_valid=%b sel=%b, expected 1 0", bus.In_valid, bus.reader_sel);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_cpu_read();
    test_alternation();
    test_credit_limit();
    test_dma_write();
    test_coincident_and_spurious();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
